// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM state type and rw encoding for the banked RAM.
package ram_pkg;
    typedef enum logic {CLEAR, READY} state_t;
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
endpackage

// File: rtl/ram_bank.sv
// ram_bank: one DATA_W x 2^ROW_W synchronous single-port bank with registered read data.
module ram_bank #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [2**ROW_W];

    always_ff @(posedge clk) begin
        if (we) mem[row] <= din;
        if (re) dout <= mem[row];
    end
endmodule

// File: rtl/ram_banked.sv
// ram_banked: banked single-port RAM with registered read path and a
// clear engine that zeroes one row of every bank per cycle after reset or clr.
module ram_banked
    import ram_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int BANK_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              clr,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);
    localparam int ROW_W = ADDR_W - BANK_BITS;
    localparam int BANKS = 1 << BANK_BITS;

    state_t                state, state_nx;
    logic [ROW_W-1:0]      row, row_sel;
    logic [BANK_BITS-1:0]  bank, sel;
    logic                  clearing, start_clr, acc, rd_q;
    logic [BANKS-1:0]      we, re;
    logic [DATA_W-1:0]     dout [BANKS];
    logic [DATA_W-1:0]     rdata;

    assign bank      = address[ADDR_W-1 -: BANK_BITS];
    assign clearing  = (state == CLEAR);
    assign start_clr = !clearing && clr;
    assign acc       = !clearing && !clr && en;
    assign row_sel   = clearing ? row : address[ROW_W-1:0];
    assign busy      = clearing;

    always_comb begin
        state_nx = state;
        if (clearing && &row) state_nx = READY;
        if (start_clr) state_nx = CLEAR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            row       <= '0;
            rd_q      <= 1'b0;
            sel       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            row       <= clearing ? row + ROW_W'(1) : '0;
            rd_q      <= acc && (rw == RW_READ);
            sel       <= bank;
            // a read landing on the edge that starts a clear is dropped so out_valid stays low through CLEAR
            out_valid <= rd_q && !start_clr;
            if (rd_q && !start_clr) out <= rdata;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign we[b] = clearing || (acc && rw == RW_WRITE && bank == BANK_BITS'(b));
        assign re[b] = acc && rw == RW_READ && bank == BANK_BITS'(b);
        ram_bank #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank (
            .clk  (clk),
            .we   (we[b]),
            .re   (re[b]),
            .row  (row_sel),
            .din  (clearing ? '0 : in),
            .dout (dout[b])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < BANKS; i++)
            rdata = rdata | (dout[i] & {DATA_W{sel == BANK_BITS'(i)}});
    end
endmodule
